control_scoreboard_id: RTL and testbench
========================================

Name: control_scoreboard_id

Overview:
- ID-stage hazard and writeback-ownership control for multi-cycle results (MUL/DIV unit, "LU").
- Complements EX-stage forwarding: the forwarding path consumes results already in EX/MEM or MEM/WB; this block tracks results not yet produced.
- Stalls ID on load-use, RAW-on-pending and WAW-on-pending hazards.
- Arbitrates the single regfile write port between MEM/WB and LU completions.

Parameters:
MAX_PENDING, 2, max outstanding LU ops (1..7)
CNT_W, 3, width of outstanding counter (must hold MAX_PENDING)

Ports:
clock  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high
id_valid  input  1  ID holds a real instruction
id_rs1  input  5  ID source 1
id_rs2  input  5  ID source 2
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_rd  input  5  ID destination
id_regwrite  input  1  instruction writes rd
id_is_long  input  1  instruction issues to LU
idex_memread  input  1  load in EX
idex_rd  input  5  EX destination
flush  input  1  kill ID this cycle (branch/jump)
memwb_regwrite  input  1  MEM/WB owns write port this cycle
lu_wb_valid  input  1  LU result ready
lu_wb_rd  input  5  LU result destination
lu_wb_ready  output  1  LU result accepted this cycle
wb_sel_lu  output  1  regfile write mux: 1 = LU data/rd
stall  output  1  freeze PC and IF/ID; bubble into ID/EX
pending  output  32  scoreboard bits, bit 0 always 0
busy  output  1  count != 0

Behaviour:
- State: pending[31:0] and count[CNT_W-1:0], both registered; reset clears both to 0 asynchronously.
- Outputs at reset: stall=0, lu_wb_ready=0, wb_sel_lu=0, busy=0.
- Hazard terms, all combinational from registered state and current inputs; an rsX term applies only if id_uses_rsX=1 and rsX != 0:
  - load_use: idex_memread && idex_rd != 0 && idex_rd == rsX.
  - raw: pending[rsX].
  - waw: id_regwrite && id_rd != 0 && pending[id_rd].
  - full: id_is_long && count == MAX_PENDING.
- stall = id_valid && !flush && (load_use | raw | waw | full).
- Issue = id_valid && id_is_long && !stall && !flush.
  - On issue: count+1 at next edge; pending[id_rd] set if id_rd != 0.
  - rd=0 ops are counted but not scoreboarded.
- Writeback arbitration:
  - lu_wb_ready = lu_wb_valid && !memwb_regwrite. MEM/WB always wins.
  - LU holds valid/rd stable until ready.
  - wb_sel_lu = lu_wb_ready.
- Completion = lu_wb_valid && lu_wb_ready. On completion: clear pending[lu_wb_rd] and decrement count.
- Issue and completion in the same cycle: count unchanged. Set and clear apply to different bits; same-rd is impossible because waw stalls.
- Completion with count==0 is ignored (no underflow).
- RAW release latency: completion at edge N writes the regfile at edge N; the stall drops in cycle N+1 and ID reads the regfile. No forwarding from LU.
- Flush suppresses issue and stall in that cycle. Already-issued LU ops remain pending (not squashed).
- Reset mid-operation clears the scoreboard; LU is reset by the same signal.

Optional Feature:
SCOREBOARD_STATS_EN
- Defined: adds outputs stall_cycles[31:0] and lu_conflict_cycles[31:0].
  - stall_cycles counts cycles with stall=1.
  - lu_conflict_cycles counts cycles with lu_wb_valid && memwb_regwrite.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5; ID id_rs1=5, uses_rs1=1 → stall=1 for 1 cycle. Repeat with idex_rd=0 → stall=0.
- RAW on pending: issue DIV rd=7; next instr reads rs2=7 → stall=1 until lu_wb completes (lu_wb_rd=7); stall=0 the cycle after; pending[7]=0.
- Write-port conflict: lu_wb_valid=1, rd=9, memwb_regwrite=1 for 3 cycles → lu_wb_ready=0 and wb_sel_lu=0 for those 3 cycles. Cycle 4, memwb_regwrite=0 → ready=1, wb_sel_lu=1, pending[9] cleared.
- Full: MAX_PENDING=2, issue rd=3 and rd=4 → count=2, busy=1. Third long op → stall=1. Completion of rd=3 in the same cycle as the third is presented → stall still 1 that cycle; issue occurs the next cycle, count=2.
- WAW and flush: pending[6]=1, ID writes rd=6 → stall=1; assert flush → stall=0, no issue. Long op with rd=0 → count=1, pending=0.
- Reset mid-op: two ops pending, assert reset asynchronously between edges → pending=0, count=0, busy=0 immediately.

Source files
------------

// File: rtl/control_scoreboard_id.sv
// ID-stage scoreboard for multi-cycle (LU) results: stalls on load-use / RAW / WAW / full,
// and arbitrates the single regfile write port. Optional counters under SCOREBOARD_STATS_EN.
module control_scoreboard_id #(
   parameter int MAX_PENDING = 2,
   parameter int CNT_W       = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_regwrite,
   input  logic        id_is_long,
   input  logic        idex_memread,
   input  logic [4:0]  idex_rd,
   input  logic        flush,
   input  logic        memwb_regwrite,
   input  logic        lu_wb_valid,
   input  logic [4:0]  lu_wb_rd,
   output logic        lu_wb_ready,
   output logic        wb_sel_lu,
   output logic        stall,
   output logic [31:0] pending,
   output logic        busy
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] lu_conflict_cycles
`endif
);

   logic [31:0]      pending_q;
   logic [31:0]      pending_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic rs1_live;
   logic rs2_live;
   logic load_use;
   logic raw;
   logic waw;
   logic full;
   logic issue;
   logic complete;

   // A source register only matters when it is actually read and is not x0.
   always_comb begin
      rs1_live = id_uses_rs1 && (id_rs1 != 5'd0);
      rs2_live = id_uses_rs2 && (id_rs2 != 5'd0);
      load_use = idex_memread && (idex_rd != 5'd0) &&
                 ((rs1_live && (idex_rd == id_rs1)) || (rs2_live && (idex_rd == id_rs2)));
      raw      = (rs1_live && pending_q[id_rs1]) || (rs2_live && pending_q[id_rs2]);
      waw      = id_regwrite && (id_rd != 5'd0) && pending_q[id_rd];
      full     = id_is_long && (count_q == CNT_W'(MAX_PENDING));
   end

   assign stall       = id_valid && !flush && (load_use || raw || waw || full);
   assign issue       = id_valid && id_is_long && !stall && !flush;
   assign lu_wb_ready = lu_wb_valid && !memwb_regwrite;
   assign wb_sel_lu   = lu_wb_ready;
   assign busy        = (count_q != '0);
   assign pending     = pending_q;

   // A spurious completion with nothing outstanding must not underflow the counter.
   assign complete = lu_wb_valid && lu_wb_ready && (count_q != '0);

   // Clear before set: the two can never hit the same bit because WAW stalls issue.
   always_comb begin
      pending_d = pending_q;
      if (complete) begin
         pending_d[lu_wb_rd] = 1'b0;
      end
      if (issue && (id_rd != 5'd0)) begin
         pending_d[id_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_comb begin
      count_d = count_q;
      case ({issue, complete})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

`ifdef SCOREBOARD_STATS_EN
   // Free-running event counters; wrap naturally at 2^32.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles       <= '0;
         lu_conflict_cycles <= '0;
      end else begin
         if (stall) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (lu_wb_valid && memwb_regwrite) begin
            lu_conflict_cycles <= lu_conflict_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_control_scoreboard_id.sv
// Self-checking bench for control_scoreboard_id: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model of outstanding LU ops.
module tb_control_scoreboard_id;

   localparam int MAX_PENDING = 2;
   localparam int CNT_W       = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  id_rd;
   logic        id_regwrite;
   logic        id_is_long;
   logic        idex_memread;
   logic [4:0]  idex_rd;
   logic        flush;
   logic        memwb_regwrite;
   logic        lu_wb_valid;
   logic [4:0]  lu_wb_rd;
   logic        lu_wb_ready;
   logic        wb_sel_lu;
   logic        stall;
   logic [31:0] pending;
   logic        busy;
`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] lu_conflict_cycles;
   logic [31:0] m_stall_cnt = 0;
   logic [31:0] m_conf_cnt  = 0;
`endif

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;
   bit lu_done  = 1'b0;

   // Model: destination registers of LU ops issued and not yet completed, oldest first.
   int q[$];

   logic        e_stall;
   logic        e_ready;
   logic        e_busy;
   logic        e_issue;
   logic        e_hazard;
   logic [31:0] e_pend;
   int          hit_idx;

   control_scoreboard_id #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_long(id_is_long),
      .idex_memread(idex_memread), .idex_rd(idex_rd), .flush(flush),
      .memwb_regwrite(memwb_regwrite), .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd),
      .lu_wb_ready(lu_wb_ready), .wb_sel_lu(wb_sel_lu), .stall(stall),
      .pending(pending), .busy(busy)
`ifdef SCOREBOARD_STATS_EN
      , .stall_cycles(stall_cycles), .lu_conflict_cycles(lu_conflict_cycles)
`endif
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit model_pending(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i] == int'(r)) return 1'b1;
      return 1'b0;
   endfunction

   // Every cycle: derive expected outputs from the outstanding-op set, compare, then advance the model.
   always @(negedge clock) begin
      if (check_en && !reset) begin
         e_hazard = 1'b0;
         if (id_uses_rs1 && id_rs1 != 0 && ((idex_memread && idex_rd == id_rs1) || model_pending(id_rs1)))
            e_hazard = 1'b1;
         if (id_uses_rs2 && id_rs2 != 0 && ((idex_memread && idex_rd == id_rs2) || model_pending(id_rs2)))
            e_hazard = 1'b1;
         if (id_regwrite && model_pending(id_rd)) e_hazard = 1'b1;
         if (id_is_long && q.size() == MAX_PENDING) e_hazard = 1'b1;
         e_stall = id_valid && !flush && e_hazard;
         e_issue = id_valid && id_is_long && !flush && !e_stall;
         e_ready = lu_wb_valid && !memwb_regwrite;
         e_busy  = (q.size() != 0);
         e_pend  = 32'd0;
         foreach (q[i]) if (q[i] != 0) e_pend[q[i]] = 1'b1;

         checkOutput("stall", {31'd0, stall}, {31'd0, e_stall});
         checkOutput("lu_wb_ready", {31'd0, lu_wb_ready}, {31'd0, e_ready});
         checkOutput("wb_sel_lu", {31'd0, wb_sel_lu}, {31'd0, e_ready});
         checkOutput("busy", {31'd0, busy}, {31'd0, e_busy});
         checkOutput("pending", pending, e_pend);
`ifdef SCOREBOARD_STATS_EN
         checkOutput("stall_cycles", stall_cycles, m_stall_cnt);
         checkOutput("lu_conflict_cycles", lu_conflict_cycles, m_conf_cnt);
         if (e_stall) m_stall_cnt++;
         if (lu_wb_valid && memwb_regwrite) m_conf_cnt++;
`endif
         if (e_ready) begin
            lu_done = 1'b1;
            if (q.size() > 0) begin
               hit_idx = 0;
               foreach (q[i]) if (q[q.size()-1-i] == int'(lu_wb_rd)) hit_idx = q.size()-1-i;
               q.delete(hit_idx);
            end
         end
         if (e_issue) q.push_back(int'(id_rd));
      end
   end

`ifdef SCOREBOARD_STATS_EN
   always @(posedge reset) begin
      m_stall_cnt = 0;
      m_conf_cnt  = 0;
   end
`endif

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_rd = 0; id_regwrite = 0; id_is_long = 0; idex_memread = 0; idex_rd = 0;
      flush = 0; memwb_regwrite = 0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
      #1;
   endtask

   task automatic issue_long(input logic [4:0] rd);
      idle();
      id_valid = 1; id_is_long = 1; id_regwrite = 1; id_rd = rd;
   endtask

   task automatic drop_lu();
      lu_wb_valid = 0;
      lu_done = 0;
   endtask

   task automatic complete_rd(input logic [4:0] rd);
      idle();
      lu_wb_valid = 1; lu_wb_rd = rd;
      step();
      drop_lu();
   endtask

   // One random ID/EX/MEM cycle; the bench plays the LU and presents the oldest op, held until accepted.
   task automatic applyStimulus();
      step();
      if (lu_wb_valid && lu_done) drop_lu();
      if (!lu_wb_valid && q.size() > 0 && $urandom_range(0, 2) == 0) begin
         lu_wb_valid = 1;
         lu_wb_rd = 5'(q[0]);
      end
      id_valid       = ($urandom_range(0, 7) != 0);
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      id_uses_rs1    = 1'($urandom_range(0, 1));
      id_uses_rs2    = 1'($urandom_range(0, 1));
      id_rd          = 5'($urandom_range(0, 7));
      id_is_long     = ($urandom_range(0, 2) == 0);
      id_regwrite    = id_is_long ? 1'b1 : 1'($urandom_range(0, 1));
      idex_memread   = ($urandom_range(0, 3) == 0);
      idex_rd        = 5'($urandom_range(0, 7));
      flush          = ($urandom_range(0, 9) == 0);
      memwb_regwrite = 1'($urandom_range(0, 1));
   endtask

   initial begin
      reset = 1;
      idle();
      lu_wb_valid = 0;
      lu_wb_rd = 0;
      #2;
      checkOutput("reset_stall", {31'd0, stall}, 32'd0);
      checkOutput("reset_ready", {31'd0, lu_wb_ready}, 32'd0);
      checkOutput("reset_sel", {31'd0, wb_sel_lu}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_pending", pending, 32'd0);
      #10;
      reset = 0;
      check_en = 1;

      // Load-use, then the same with EX destination x0.
      step(); idle();
      idex_memread = 1; idex_rd = 5; id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5;
      sample(); checkOutput("load_use_stall", {31'd0, stall}, 32'd1);
      step(); idex_rd = 0;
      sample(); checkOutput("load_use_x0", {31'd0, stall}, 32'd0);

      // RAW on pending rd=7 released by completion.
      step(); issue_long(7);
      sample(); checkOutput("raw_issue_stall", {31'd0, stall}, 32'd0);
      step(); idle(); id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7;
      sample(); checkOutput("raw_pending", pending, 32'h0000_0080);
      checkOutput("raw_stall", {31'd0, stall}, 32'd1);
      step(); lu_wb_valid = 1; lu_wb_rd = 7;
      sample(); checkOutput("raw_stall_at_wb", {31'd0, stall}, 32'd1);
      checkOutput("raw_ready", {31'd0, lu_wb_ready}, 32'd1);
      step(); drop_lu();
      sample(); checkOutput("raw_release", {31'd0, stall}, 32'd0);
      checkOutput("raw_cleared", pending, 32'd0);

      // Write-port conflict: MEM/WB owns the port for three cycles.
      step(); issue_long(9);
      step(); idle(); lu_wb_valid = 1; lu_wb_rd = 9; memwb_regwrite = 1;
      for (int i = 0; i < 3; i++) begin
         sample();
         checkOutput("conflict_ready", {31'd0, lu_wb_ready}, 32'd0);
         checkOutput("conflict_sel", {31'd0, wb_sel_lu}, 32'd0);
         step();
      end
      memwb_regwrite = 0;
      sample(); checkOutput("conflict_win_ready", {31'd0, lu_wb_ready}, 32'd1);
      checkOutput("conflict_win_sel", {31'd0, wb_sel_lu}, 32'd1);
      step(); drop_lu();
      sample(); checkOutput("conflict_cleared", pending, 32'd0);

      // Full: two outstanding; third waits even while a completion lands.
      step(); issue_long(3);
      step(); issue_long(4);
      step(); issue_long(5); lu_wb_valid = 1; lu_wb_rd = 3;
      sample(); checkOutput("full_stall", {31'd0, stall}, 32'd1);
      checkOutput("full_pending", pending, 32'h0000_0018);
      checkOutput("full_busy", {31'd0, busy}, 32'd1);
      step(); drop_lu();
      sample(); checkOutput("full_retry", {31'd0, stall}, 32'd0);
      step(); issue_long(8);
      sample(); checkOutput("full_again", {31'd0, stall}, 32'd1);
      checkOutput("full_pending2", pending, 32'h0000_0030);
      step(); complete_rd(4); complete_rd(5);
      sample(); checkOutput("full_drained", {31'd0, busy}, 32'd0);

      // WAW and flush, then an rd=0 long op.
      step(); issue_long(6);
      step(); idle(); id_valid = 1; id_regwrite = 1; id_rd = 6;
      sample(); checkOutput("waw_stall", {31'd0, stall}, 32'd1);
      step(); id_is_long = 1; flush = 1;
      sample(); checkOutput("waw_flush", {31'd0, stall}, 32'd0);
      step(); issue_long(10); flush = 1;
      sample(); checkOutput("flush_stall", {31'd0, stall}, 32'd0);
      step(); idle();
      sample(); checkOutput("flush_no_issue", pending, 32'h0000_0040);
      step(); issue_long(0);
      step(); idle();
      sample(); checkOutput("rd0_pending", pending, 32'h0000_0040);
      step(); complete_rd(6);
      sample(); checkOutput("rd0_busy", {31'd0, busy}, 32'd1);
      checkOutput("rd0_cleared", pending, 32'd0);
      step(); complete_rd(0);
      sample(); checkOutput("rd0_done", {31'd0, busy}, 32'd0);

      // Completion with nothing outstanding must not underflow.
      step(); lu_wb_valid = 1; lu_wb_rd = 0;
      step(); drop_lu(); issue_long(11);
      step(); complete_rd(11);
      sample(); checkOutput("no_underflow", {31'd0, busy}, 32'd0);

      // Asynchronous reset between edges with two ops outstanding.
      step(); issue_long(12);
      step(); issue_long(13);
      step(); idle();
      sample(); checkOutput("pre_reset_pending", pending, 32'h0000_3000);
      #2 reset = 1;
      #1;
      checkOutput("async_pending", pending, 32'd0);
      checkOutput("async_busy", {31'd0, busy}, 32'd0);
      q.delete();
      drop_lu();
      @(posedge clock);
      #3 reset = 0;

      for (int n = 0; n < 3000; n++) applyStimulus();
      step(); idle(); drop_lu();
      sample();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
